md_unit_ctrl: RTL and testbench

- Sequences the multiply/divide unit of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and models the fixed multi-cycle latency of each operation.
- Owns the HI/LO registers.
- Generates the D-stage stall that holds any HI/LO-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is busy or being started.

---
 rtl/md_unit_ctrl.sv | 139 +++++++++++++
 tb/tb_md_unit_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide unit sequencer: owns HI/LO, models fixed op latency and
// raises the D-stage stall for HI/LO-class instructions.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] op_a, op_a_nxt;
    logic [DW-1:0] op_b, op_b_nxt;
    logic [2:0]    op_code, op_code_nxt;
    logic [DW-1:0] hi_nxt, lo_nxt;

    logic          start_op;
    logic [63:0]   prod_s, prod_u;
    logic [DW-1:0] quot_s, rem_s, quot_u, rem_u;

    // E-stage op that would start a multi-cycle operation
    assign start_op = (e_op >= OP_MULT) && (e_op <= OP_DIVU);

    assign busy     = (state == BUSY);
    assign stall_md = d_is_md && (busy || (start_op && !flush));

    // Results from the latched operands; only sampled on the completion edge
    always_comb begin
        prod_s = 64'($signed(op_a)) * 64'($signed(op_b));
        prod_u = 64'(op_a) * 64'(op_b);
        quot_s = DW'($signed(op_a) / $signed(op_b));
        rem_s  = DW'($signed(op_a) % $signed(op_b));
        quot_u = op_a / op_b;
        rem_u  = op_a % op_b;
    end

    // Next-state, counter, operand latch and HI/LO update
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_a_nxt    = op_a;
        op_b_nxt    = op_b;
        op_code_nxt = op_code;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (start_op) begin
                        state_nxt   = BUSY;
                        op_a_nxt    = e_rs;
                        op_b_nxt    = e_rt;
                        op_code_nxt = e_op;
                        cnt_nxt     = (e_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    end else if (e_op == OP_MTHI) begin
                        hi_nxt = e_rs;
                    end else if (e_op == OP_MTLO) begin
                        lo_nxt = e_rs;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    case (op_code)
                        OP_MULT: begin
                            hi_nxt = prod_s[63:32];
                            lo_nxt = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_nxt = prod_u[63:32];
                            lo_nxt = prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (op_b != '0) begin
                                hi_nxt = rem_s;
                                lo_nxt = quot_s;
                            end
                        end
                        OP_DIVU: begin
                            if (op_b != '0) begin
                                hi_nxt = rem_u;
                                lo_nxt = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_a    <= op_a_nxt;
            op_b    <= op_b_nxt;
            op_code <= op_code_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic, stall, flush, reset.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  e_op;
    logic [31:0] e_rs, e_rt;
    logic        flush;
    logic        d_is_md;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
        .flush(flush), .d_is_md(d_is_md), .busy(busy), .stall_md(stall_md),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // An HI/LO-class op must never reach E while the unit is busy
    always @(posedge clk) begin
        if (reset === 1'b1 && busy === 1'b1)
            chk("md_op_in_busy", 32'(e_op >= 3'd1 && e_op <= 3'd6 && !flush), 32'd0);
    end

    // Issue one op, check the stall and busy window, then the committed HI/LO
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dmd, input int n,
                          input int flush_at, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        e_op = op; e_rs = a; e_rt = b; d_is_md = dmd;
        #1;
        chk({tag, "_issue_stall"}, 32'(stall_md), 32'(dmd));
        chk({tag, "_issue_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        e_op = 3'd0;
        for (int i = 0; i < n; i++) begin
            flush = (i == flush_at);
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_stall"}, 32'(stall_md), 32'(dmd));
            @(negedge clk);
        end
        flush = 1'b0;
        #1;
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_stall"}, 32'(stall_md), 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    // Single-cycle mthi/mtlo write
    task automatic mt_op(input logic [2:0] op, input logic [31:0] v, input logic fl);
        @(negedge clk);
        e_op = op; e_rs = v; flush = fl; d_is_md = 1'b0;
        @(negedge clk);
        e_op = 3'd0; flush = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; e_op = 3'd0; e_rs = '0; e_rt = '0; flush = 1'b0; d_is_md = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_md), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // mthi, then mtlo under flush must leave lo alone
        mt_op(3'd5, 32'hDEADBEEF, 1'b0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_busy", 32'(busy), 32'd0);
        mt_op(3'd6, 32'h12345678, 1'b1);
        chk("mtlo_flush_lo", lo, 32'd0);
        mt_op(3'd6, 32'h0000ABCD, 1'b0);
        chk("mtlo_lo", lo, 32'h0000ABCD);

        run_op("mult",  3'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 5,  -1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5,  -1, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 10, -1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'd4, 32'd7,        32'd2, 1'b1, 10, -1, 32'd1,        32'd3);

        // Flush on the issue cycle: no busy, no stall, HI/LO untouched
        @(negedge clk);
        e_op = 3'd3; e_rs = 32'd9; e_rt = 32'd4; flush = 1'b1; d_is_md = 1'b1;
        #1;
        chk("flush_issue_stall", 32'(stall_md), 32'd0);
        @(negedge clk);
        e_op = 3'd0; flush = 1'b0;
        #1;
        chk("flush_issue_busy", 32'(busy), 32'd0);
        chk("flush_issue_hi", hi, 32'd1);
        chk("flush_issue_lo", lo, 32'd3);

        // Flush during BUSY cycle 2 does not cancel the running op
        run_op("divu_fl", 3'd4, 32'd100, 32'd7, 1'b1, 10, 1, 32'd2, 32'd14);

        // Divide by zero keeps preset HI/LO
        mt_op(3'd5, 32'h11, 1'b0);
        mt_op(3'd6, 32'h22, 1'b0);
        run_op("div0", 3'd3, 32'd5, 32'd0, 1'b1, 10, -1, 32'h11, 32'h22);

        // Reset mid-BUSY: immediate clear, no late commit
        mt_op(3'd5, 32'hCAFE0000, 1'b0);
        @(negedge clk);
        e_op = 3'd1; e_rs = 32'd3; e_rt = 32'd4; d_is_md = 1'b0;
        @(negedge clk);
        e_op = 3'd0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rstmid_late_busy", 32'(busy), 32'd0);
        chk("rstmid_late_hi", hi, 32'd0);
        chk("rstmid_late_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
